sipo_load_ctrl: RTL and testbench
=================================

# sipo_load_ctrl

Serial-to-parallel word assembler and load sequencer. Accepts one bit per handshake into an internal shift register (serial input at the MSB, shifting right), counts `DW` accepted bits, then pulses the enable of an internal parallel-in/parallel-out holding register. The assembled word is presented downstream under a valid/ready handshake. It sits between a bit-serial source and any word-wide consumer in the datapath.

## Interface
- `DW`, default 4: word width in bits; legal range DW >= 2.
- `CW`, default `$clog2(DW)`: bit-counter width (derived; not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin assembling a new word; sampled only in IDLE, or in WAIT on the handshake cycle.
- `ser_in`  in  1  serial data bit.
- `ser_vld`  in  1  `ser_in` is valid.
- `ser_rdy`  out  1  controller accepts a bit this cycle. A bit is accepted when `ser_vld && ser_rdy`.
- `out_data`  out  DW  holding-register contents.
- `out_vld`  out  1  `out_data` holds a new word.
- `out_rdy`  in  1  consumer takes the word. The word is taken when `out_vld && out_rdy`.
- `busy`  out  1  high in every state except IDLE.
- `bit_cnt`  out  CW  number of bits accepted so far in the current word.

## Operation
- The FSM has four states: IDLE, SHIFT, LOAD, WAIT. All outputs are Moore, decoded from registered state.
- **IDLE**
  - `ser_rdy`=0, `out_vld`=0, `busy`=0.
  - `start`=1 -> SHIFT; `bit_cnt` is cleared to 0.
- **SHIFT**
  - `ser_rdy`=1.
  - On accept: `sr <= {ser_in, sr[DW-1:1]}` and `bit_cnt` increments.
  - Accept while `bit_cnt == DW-1` -> LOAD; `bit_cnt` wraps to 0.
  - `ser_vld`=0 stalls: no shift, no count change.
- **LOAD**
  - `ser_rdy`=0.
  - The holding-register enable is asserted for exactly this cycle: `out_data <= sr`.
  - Unconditional transition -> WAIT.
- **WAIT**
  - `out_vld`=1.
  - On `out_rdy`: with `start`=1 -> SHIFT (`bit_cnt`=0, back-to-back words); otherwise -> IDLE.
  - No bits are accepted while in WAIT.
- **Bit order:** the first accepted bit ends at `out_data[0]`; the last accepted bit ends at `out_data[DW-1]`.
- **Holding register:** `out_data` changes only in LOAD. It stays stable through WAIT and after the handshake until the next LOAD.
- **`start` elsewhere:** ignored in SHIFT, in LOAD, and in WAIT without `out_rdy`.
- **Reset:** `rst`=1 in any state, including mid-word, forces IDLE and clears `sr`, `out_data`, and `bit_cnt`.
  - Outputs on the cycle after reset: `ser_rdy`=0, `out_vld`=0, `busy`=0, `out_data`=0, `bit_cnt`=0.
  - A partially assembled word is discarded.

## Timing
- `start` sampled at edge N -> `ser_rdy`=1 and `busy`=1 from cycle N+1.
- With `ser_vld` held high: bits are accepted in cycles N+1..N+DW, LOAD occurs in N+DW+1, and `out_vld`=1 from N+DW+2.
- Latency from the last bit accept to `out_vld` is 2 cycles.
- Minimum word period with continuous `start`, `ser_vld`, and `out_rdy` is DW+2 cycles:
  - DW accept cycles;
  - the LOAD cycle;
  - the WAIT cycle, which completes the handshake and returns to SHIFT.
- `out_vld` falls on the cycle after the handshake.
- `bit_cnt` is registered; it reflects the accepts completed before the current cycle.

## Test plan
- **Reset value:** assert `rst` for 2 cycles, then release.
  - Required: `ser_rdy`=0, `out_vld`=0, `busy`=0, `out_data`=0, `bit_cnt`=0.
- **Basic word, DW=4:** `start` pulse, then bits 1,0,1,1 on consecutive cycles with `ser_vld`=1 and `out_rdy`=1.
  - Required: `out_data`=4'hD; `out_vld` rises 2 cycles after the 4th accept, is high for 1 cycle, then the FSM returns to IDLE.
- **Stalls on both sides:** same bits as above, with `ser_vld` dropped for 3 cycles after bit 2 and `out_rdy` held 0 for 5 cycles.
  - Required: `bit_cnt` holds at 2 during the `ser_vld` stall; `out_vld` stays high with `out_data`=4'hD stable until `out_rdy`; no `ser_rdy` during WAIT.
- **Back-to-back words:** word 4'hD then 4'h6 (bits 0,1,1,0), with `start`=1 on the WAIT handshake cycle.
  - Required: no IDLE cycle between the words; second `out_data`=4'h6; word period is 6 cycles.
- **Reset mid-word:** assert `rst` after 2 accepted bits, then start a fresh word 0,0,0,1.
  - Required: after reset `bit_cnt`=0 and `out_data`=0; the fresh word gives `out_data`=4'h8, unaffected by the discarded bits.
- **Ignored start:** pulse `start` during SHIFT and again during WAIT with `out_rdy`=0.
  - Required: `bit_cnt` is not cleared, the state is unchanged, and the word completes normally.

Source files
------------

// File: rtl/sipo_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sipo_load_ctrl
// Description : Serial-to-parallel word assembler. It shifts in DW bits under
//               a valid/ready handshake, loads a holding register, and offers
//               the finished word downstream under a second valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_load_ctrl #(
    parameter int DW = 4,
    parameter int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ser_in,
    input  logic          ser_vld,
    output logic          ser_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic          busy,
    output logic [CW-1:0] bit_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [CW-1:0] c_last_bit = CW'(DW - 1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_sr;
    logic [DW-1:0] r_out_data;
    logic [CW-1:0] r_bit_cnt;
    logic          w_accept;

    assign w_accept = ser_vld && (r_state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_out_data <= '0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_accept) begin
                        // New bit enters at the MSB so the first bit lands in bit 0.
                        r_sr <= {ser_in, r_sr[DW-1:1]};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_LOAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    r_out_data <= r_sr;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (out_rdy) begin
                        if (start) begin
                            r_state   <= S_SHIFT;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ser_rdy  = (r_state == S_SHIFT);
    assign out_vld  = (r_state == S_WAIT);
    assign busy     = (r_state != S_IDLE);
    assign out_data = r_out_data;
    assign bit_cnt  = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_load_ctrl
// Description : Self-checking bench for sipo_load_ctrl (DW=4) with directed
//               scenarios and randomized words against a bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_load_ctrl;

    localparam int DW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ser_in = 1'b0;
    logic          ser_vld = 1'b0;
    logic          ser_rdy;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy = 1'b0;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sipo_load_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_vld(ser_vld),
        .ser_rdy(ser_rdy), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .busy(busy), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Feed the bits of w, LSB first, on consecutive cycles (stimulus only).
    task automatic feed(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            ser_in  = w[i];
            ser_vld = 1'b1;
            tick();
        end
        ser_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (ser_rdy !== 1'b0) begin errors++; $display("FAIL reset_ser_rdy got=%b exp=0", ser_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (bit_cnt !== 2'd0) begin errors++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] bits;
        int t_last;
        bits = 4'b1101;  // sent 1,0,1,1
        out_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (ser_rdy !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_start got rdy=%b busy=%b exp 1 1", ser_rdy, busy); end
        for (int i = 0; i < DW; i++) begin
            ser_in = bits[i];
            ser_vld = 1'b1;
            tick();
            checks++; if (bit_cnt !== CW'((i + 1) % DW)) begin errors++; $display("FAIL basic_bit_cnt%0d got=%0d exp=%0d", i, bit_cnt, (i + 1) % DW); end
        end
        ser_vld = 1'b0;
        t_last = cyc;
        checks++; if (out_vld !== 1'b0 || ser_rdy !== 1'b0) begin errors++; $display("FAIL basic_load got vld=%b rdy=%b exp 0 0", out_vld, ser_rdy); end
        tick();
        checks++; if (out_vld !== 1'b1 || cyc - t_last != 1) begin errors++; $display("FAIL basic_vld_latency got vld=%b exp 1", out_vld); end
        checks++; if (out_data !== 4'hD) begin errors++; $display("FAIL basic_data got=%h exp=d", out_data); end
        tick();
        checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== 4'hD) begin errors++; $display("FAIL basic_idle got vld=%b busy=%b data=%h exp 0 0 d", out_vld, busy, out_data); end
        out_rdy = 1'b0;
    endtask

    task automatic test_stalls();
        logic [DW-1:0] bits;
        bits = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ser_in = bits[i]; ser_vld = 1'b1; tick();
        end
        ser_vld = 1'b0;
        ser_in = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++; if (bit_cnt !== 2'd2 || ser_rdy !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got cnt=%0d rdy=%b exp 2 1", s, bit_cnt, ser_rdy); end
        end
        for (int i = 2; i < DW; i++) begin
            ser_in = bits[i]; ser_vld = 1'b1; tick();
        end
        tick();  // LOAD -> WAIT; keep ser_vld high to probe for stray accepts
        for (int s = 0; s < 5; s++) begin
            checks++; if (out_vld !== 1'b1 || out_data !== 4'hD || ser_rdy !== 1'b0) begin errors++; $display("FAIL stall_wait%0d got vld=%b data=%h rdy=%b exp 1 d 0", s, out_vld, out_data, ser_rdy); end
            tick();
        end
        ser_vld = 1'b0;
        out_rdy = 1'b1;
        tick();
        checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== 4'hD) begin errors++; $display("FAIL stall_done got vld=%b busy=%b data=%h exp 0 0 d", out_vld, busy, out_data); end
        out_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        out_rdy = 1'b1;
        start = 1'b1;
        tick();
        feed(4'hD);
        tick();  // now in WAIT; start still high for the handshake
        t1 = cyc;
        checks++; if (out_vld !== 1'b1 || out_data !== 4'hD) begin errors++; $display("FAIL b2b_word1 got vld=%b data=%h exp 1 d", out_vld, out_data); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || ser_rdy !== 1'b1 || bit_cnt !== 2'd0) begin errors++; $display("FAIL b2b_no_idle got busy=%b rdy=%b cnt=%0d exp 1 1 0", busy, ser_rdy, bit_cnt); end
        feed(4'h6);
        tick();
        t2 = cyc;
        checks++; if (out_vld !== 1'b1 || out_data !== 4'h6) begin errors++; $display("FAIL b2b_word2 got vld=%b data=%h exp 1 6", out_vld, out_data); end
        checks++; if (t2 - t1 != DW + 2) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", t2 - t1, DW + 2); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
        out_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        out_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ser_vld = 1'b1; ser_in = 1'b1; tick(); tick();
        ser_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bit_cnt !== 2'd0 || out_data !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_clear got cnt=%0d data=%h busy=%b exp 0 0 0", bit_cnt, out_data, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(4'h8);
        tick();
        checks++; if (out_vld !== 1'b1 || out_data !== 4'h8) begin errors++; $display("FAIL midrst_word got vld=%b data=%h exp 1 8", out_vld, out_data); end
        tick();
        out_rdy = 1'b0;
    endtask

    task automatic test_ignored_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        ser_vld = 1'b1; ser_in = 1'b0; tick();
        ser_in = 1'b1; tick();
        ser_vld = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (bit_cnt !== 2'd2 || ser_rdy !== 1'b1) begin errors++; $display("FAIL ign_shift got cnt=%0d rdy=%b exp 2 1", bit_cnt, ser_rdy); end
        ser_vld = 1'b1; ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        ser_vld = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (out_vld !== 1'b1 || ser_rdy !== 1'b0 || out_data !== 4'h6) begin errors++; $display("FAIL ign_wait got vld=%b rdy=%b data=%h exp 1 0 6", out_vld, ser_rdy, out_data); end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        checks++; if (busy !== 1'b0 || out_data !== 4'h6) begin errors++; $display("FAIL ign_done got busy=%b data=%h exp 0 6", busy, out_data); end
    endtask

    // Random words with random source stalls and consumer back-pressure.
    task automatic test_random_words();
        bit   q[$];
        logic [DW-1:0] exp_word;
        int   n_acc;
        int   guard;
        int   wait_cyc;
        for (int w = 0; w < 10; w++) begin
            q.delete();
            start = 1'b1;
            tick();
            start = 1'b0;
            n_acc = 0;
            guard = 0;
            while (n_acc < DW && guard < 200) begin
                ser_vld = 1'($urandom_range(0, 1));
                ser_in  = 1'($urandom_range(0, 1));
                if (ser_rdy && ser_vld) begin
                    q.push_back(ser_in);
                    n_acc++;
                end
                tick();
                guard++;
                checks++; if (bit_cnt !== CW'(n_acc % DW)) begin errors++; $display("FAIL rand_cnt w%0d got=%0d exp=%0d", w, bit_cnt, n_acc % DW); end
            end
            ser_vld = 1'b1;
            if (guard >= 200) begin
                errors++;
                $display("FAIL rand_timeout w%0d accepted=%0d exp=%0d", w, n_acc, DW);
            end
            exp_word = '0;
            for (int i = 0; i < q.size(); i++) exp_word = exp_word | (DW'(q[i]) << i);
            tick();
            wait_cyc = $urandom_range(0, 3);
            for (int s = 0; s <= wait_cyc; s++) begin
                checks++; if (out_vld !== 1'b1 || ser_rdy !== 1'b0 || out_data !== exp_word) begin errors++; $display("FAIL rand_word w%0d got vld=%b rdy=%b data=%h exp 1 0 %h", w, out_vld, ser_rdy, out_data, exp_word); end
                if (s < wait_cyc) tick();
            end
            ser_vld = 1'b0;
            out_rdy = 1'b1;
            tick();
            out_rdy = 1'b0;
            checks++; if (busy !== 1'b0 || out_vld !== 1'b0) begin errors++; $display("FAIL rand_idle w%0d got busy=%b vld=%b exp 0 0", w, busy, out_vld); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_back_to_back();
        test_reset_mid_word();
        test_ignored_start();
        test_random_words();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
